cpu_fetch_queue: RTL and testbench

//  Instruction-byte fetch stage directly upstream of simple_cpu decode/execute.

---
 rtl/cpu_fetch_queue_pkg.sv | 21 ++
 rtl/cpu_fetch_queue_fifo.sv | 70 +++++++
 rtl/cpu_fetch_queue.sv | 144 ++++++++++++++
 tb/tb_cpu_fetch_queue.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_fetch_queue_pkg.sv
// Shared CPU fetch definitions: bus widths, reset vector and fetch FSM states.
package cpu_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    localparam logic [ADDR_W-1:0] RESET_VECTOR = 16'hFFFC;

    typedef enum logic [1:0] {
        VEC_LO,
        VEC_HI,
        VEC_WAIT,
        RUN
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/cpu_fetch_queue_fifo.sv
// Prefetch queue of {pc, byte} entries with flush; head output holds its last
// value while the queue is empty.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             wdata,
    output fetch_entry_t             rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    fetch_entry_t      mem [DEPTH];
    fetch_entry_t      hold;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;
    logic              not_empty;

    assign not_empty = (count != '0);
    assign do_push   = push && (count < FULL);
    assign do_pop    = pop && not_empty;
    assign rdata     = not_empty ? mem[rd_ptr] : hold;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            hold   <= '0;
        end else begin
            // Track the visible head so it stays put once the queue drains.
            if (not_empty) begin
                hold <= mem[rd_ptr];
            end
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push) begin
                    mem[wr_ptr] <= wdata;
                    wr_ptr      <= wr_ptr + AW'(1);
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                case ({do_push, do_pop})
                    2'b10:   count <= count + (AW+1)'(1);
                    2'b01:   count <= count - (AW+1)'(1);
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/cpu_fetch_queue.sv
// Instruction-byte fetch stage: loads the reset vector, then prefetches bytes
// into a small queue for decode. Optional push counter under FETCH_COUNT_EN.
//
// state    | meaning
// VEC_LO   | read vector low byte
// VEC_HI   | read vector high byte, capture low byte
// VEC_WAIT | capture high byte
// RUN      | stream bytes from fetch_pc into the queue
module cpu_fetch_queue
    import cpu_pkg::*;
#(
    parameter int                DEPTH       = 4,
    parameter logic [ADDR_W-1:0] VECTOR_ADDR = RESET_VECTOR
)
(
    input  logic              clk,
    input  logic              reset,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              ir_valid,
    output logic [DATA_W-1:0] ir_byte,
    output logic [ADDR_W-1:0] ir_pc,
    input  logic              ir_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc
`ifdef FETCH_COUNT_EN
    ,
    output logic [ADDR_W-1:0] fetch_count
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_state_t      state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight;
    logic [CW-1:0]     count;
    logic              run;
    logic              kill;
    logic              issue;
    logic              push;
    logic              pop;
    logic              rd_c;
    logic [ADDR_W-1:0] addr_c;
    fetch_entry_t      wentry;
    fetch_entry_t      head;

    assign run   = (state == RUN);
    assign kill  = run && redirect;
    // Credits count queued plus in-flight bytes, so a full queue can never overflow.
    assign issue = run && !redirect && ((count + CW'(inflight)) < DEPTH_C);
    assign push  = inflight && !kill;
    assign pop   = ir_valid && ir_ready;

    assign wentry.pc   = inflight_pc;
    assign wentry.data = mem_rdata;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (kill),
        .wdata (wentry),
        .rdata (head),
        .count (count)
    );

    assign ir_valid = run && (count != '0);
    assign ir_byte  = head.data;
    assign ir_pc    = head.pc;

    always_comb begin
        rd_c   = 1'b0;
        addr_c = '0;
        case (state)
            VEC_LO: begin
                rd_c   = 1'b1;
                addr_c = VECTOR_ADDR;
            end
            VEC_HI: begin
                rd_c   = 1'b1;
                addr_c = VECTOR_ADDR + ADDR_W'(1);
            end
            RUN: begin
                rd_c   = issue;
                addr_c = fetch_pc;
            end
            default: ;
        endcase
    end

    // Reset forces the bus idle immediately, not just at the next edge.
    assign mem_rd   = rd_c && !reset;
    assign mem_addr = reset ? '0 : addr_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= VEC_LO;
            fetch_pc    <= '0;
            inflight_pc <= '0;
            inflight    <= 1'b0;
        end else begin
            case (state)
                VEC_LO: state <= VEC_HI;
                VEC_HI: begin
                    fetch_pc[DATA_W-1:0] <= mem_rdata;
                    state                <= VEC_WAIT;
                end
                VEC_WAIT: begin
                    fetch_pc[ADDR_W-1:DATA_W] <= mem_rdata;
                    state                     <= RUN;
                end
                RUN: begin
                    if (redirect) begin
                        fetch_pc <= redirect_pc;
                        inflight <= 1'b0;
                    end else begin
                        inflight <= issue;
                        if (issue) begin
                            inflight_pc <= fetch_pc;
                            fetch_pc    <= fetch_pc + ADDR_W'(1);
                        end
                    end
                end
                default: state <= VEC_LO;
            endcase
        end
    end

`ifdef FETCH_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count <= '0;
        end else if (push) begin
            fetch_count <= fetch_count + ADDR_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_cpu_fetch_queue.sv
// Self-checking bench for cpu_fetch_queue: vector-load table, hand-written
// backpressure/redirect/reset sequences and a randomized run against a byte-stream model.
module tb_cpu_fetch_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata = 8'h00;
    logic        ir_valid;
    logic [7:0]  ir_byte;
    logic [15:0] ir_pc;
    logic        ir_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
`ifdef FETCH_COUNT_EN
    logic [15:0] fetch_count;
`endif

    cpu_fetch_queue dut (
        .clk         (clk),
        .reset       (reset),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .ir_valid    (ir_valid),
        .ir_byte     (ir_byte),
        .ir_pc       (ir_pc),
        .ir_ready    (ir_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
`ifdef FETCH_COUNT_EN
        ,
        .fetch_count (fetch_count)
`endif
    );

    always #10 clk = ~clk;

    logic [7:0] ram [65536];
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= ram[mem_addr];
    end

    int checks = 0;
    int errors = 0;

    // Abstract model: bytes decode should see, queue occupancy and outstanding read.
    bit          mdl_on = 1'b0;
    int          occ = 0;
    bit          infl = 1'b0;
    logic [15:0] exp_pc = 16'h0000;
    int          pushes_m = 0;
    logic [15:0] popped [$];

    typedef struct {
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [15:0] first_pc;
    } vec_t;
    vec_t vec_tbl [3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Called at posedge+1 with inputs already driven; ends at the next posedge+1.
    task automatic tick();
        bit issue_m;
        bit pop_m;
        #1;
        if (mdl_on) begin
            issue_m = ((occ + int'(infl)) < 4) && !redirect;
            pop_m   = (occ > 0) && ir_ready && !redirect;
            chk("mem_rd_credit", 32'(mem_rd), 32'(issue_m));
            chk("ir_valid", 32'(ir_valid), 32'(occ > 0));
`ifdef FETCH_COUNT_EN
            chk("fetch_count", 32'(fetch_count), 32'(pushes_m[15:0]));
`endif
            if (pop_m) begin
                chk("ir_pc", 32'(ir_pc), 32'(exp_pc));
                chk("ir_byte", 32'(ir_byte), 32'(ram[exp_pc]));
                popped.push_back(ir_pc);
                exp_pc = exp_pc + 16'd1;
            end
            if (redirect) begin
                occ    = 0;
                infl   = 1'b0;
                exp_pc = redirect_pc;
            end else begin
                if (infl) pushes_m++;
                occ  = occ + int'(infl) - int'(pop_m);
                infl = issue_m;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load_vector(input vec_t v);
        mdl_on   = 1'b0;
        reset    = 1'b1;
        ir_ready = 1'b1;
        redirect = 1'b0;
        redirect_pc = 16'h0000;
        ram[16'hFFFC] = v.lo;
        ram[16'hFFFD] = v.hi;
        @(posedge clk);
        #1;
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_ir_valid", 32'(ir_valid), 32'd0);
        chk("rst_ir_pc", 32'(ir_pc), 32'd0);
        chk("rst_ir_byte", 32'(ir_byte), 32'd0);
        reset = 1'b0;
        #1;
        chk("vec_lo_rd", 32'(mem_rd), 32'd1);
        chk("vec_lo_addr", 32'(mem_addr), 32'h0000FFFC);
        chk("vec_lo_valid", 32'(ir_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("vec_hi_rd", 32'(mem_rd), 32'd1);
        chk("vec_hi_addr", 32'(mem_addr), 32'h0000FFFD);
        @(posedge clk);
        #1;
        chk("vec_wait_rd", 32'(mem_rd), 32'd0);
        @(posedge clk);
        #1;
        chk("run_first_addr", 32'(mem_addr), 32'(v.first_pc));
        mdl_on   = 1'b1;
        occ      = 0;
        infl     = 1'b0;
        exp_pc   = v.first_pc;
        pushes_m = 0;
        popped.delete();
    endtask

    initial begin
        logic [15:0] h;
        logic [15:0] p;
        logic [7:0]  prog [8];

        vec_tbl[0] = '{lo: 8'h00, hi: 8'h80, first_pc: 16'h8000};
        vec_tbl[1] = '{lo: 8'hFE, hi: 8'hFF, first_pc: 16'hFFFE};
        vec_tbl[2] = '{lo: 8'h34, hi: 8'h12, first_pc: 16'h1234};
        prog = '{8'hA9, 8'h01, 8'h8D, 8'h00, 8'h02, 8'hEA, 8'hEA, 8'h4C};

        for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
        for (int i = 0; i < 8; i++) ram[16'h8000 + i] = prog[i];

        for (int t = 0; t < 3; t++) begin
            load_vector(vec_tbl[t]);
            for (int c = 0; c < 10; c++) tick();
            chk("stream_count", 32'(popped.size()), 32'd8);
            for (int i = 0; i < popped.size() && i < 8; i++) begin
                p = vec_tbl[t].first_pc + 16'(i);
                chk("stream_pc", 32'(popped[i]), 32'(p));
            end
            if (t == 0) begin
                for (int i = 0; i < 8; i++)
                    chk("prog_byte", 32'(ram[16'h8000 + i]), 32'(prog[i]));

                ir_ready = 1'b0;
                for (int c = 0; c < 10; c++) tick();
                h = exp_pc;
                chk("bp_mem_rd", 32'(mem_rd), 32'd0);
                chk("bp_valid", 32'(ir_valid), 32'd1);
                chk("bp_head", 32'(ir_pc), 32'(h));
                ir_ready = 1'b1;
                tick();
                ir_ready = 1'b0;
                #1;
                chk("bp_resume_rd", 32'(mem_rd), 32'd1);
                chk("bp_resume_addr", 32'(mem_addr), 32'(h + 16'd4));
                tick();
                redirect    = 1'b1;
                redirect_pc = 16'h9000;
                tick();
                redirect = 1'b0;
                ir_ready = 1'b1;
                popped.delete();
                #1;
                chk("redir_flush", 32'(ir_valid), 32'd0);
                chk("redir_rd", 32'(mem_rd), 32'd1);
                chk("redir_addr", 32'(mem_addr), 32'h00009000);
                for (int c = 0; c < 6; c++) tick();
                chk("redir_count", 32'(popped.size()), 32'd4);
                for (int i = 0; i < popped.size(); i++) begin
                    p = popped[i];
                    chk("redir_no_old", 32'(p[15:12]), 32'h9);
                end
                if (popped.size() >= 2) begin
                    chk("redir_pc0", 32'(popped[0]), 32'h00009000);
                    chk("redir_pc1", 32'(popped[1]), 32'h00009001);
                end
            end
        end

        // Randomized traffic with frequent backpressure and redirects.
        for (int c = 0; c < 3000; c++) begin
            ir_ready = ($urandom_range(0, 3) != 0);
            redirect = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0)
                redirect_pc = 16'hFFFC + 16'($urandom_range(0, 7));
            else
                redirect_pc = 16'($urandom);
            tick();
        end
        redirect = 1'b0;
        ir_ready = 1'b1;
        for (int c = 0; c < 6; c++) tick();

        // Asynchronous reset between edges.
        #3;
        reset = 1'b1;
        #1;
        chk("async_rst_valid", 32'(ir_valid), 32'd0);
        chk("async_rst_rd", 32'(mem_rd), 32'd0);
        load_vector(vec_tbl[0]);
        for (int c = 0; c < 6; c++) tick();
        if (popped.size() > 0)
            chk("rst_refetch_pc", 32'(popped[0]), 32'h00008000);
        else
            chk("rst_refetch_count", 32'(popped.size()), 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
